// File: rtl/down_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_timer_pkg
//   Shared definitions for the down_timer block.
//   - state_t       : FSM state encoding (IDLE, RUN, EXPIRE)
//   - DEFAULT_WIDTH : default count/reload/load path width
// -----------------------------------------------------------------------------
package down_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    EXPIRE = 2'b10
  } state_t;

endpackage : down_timer_pkg

// File: rtl/down_timer_cnt.sv
// -----------------------------------------------------------------------------
// down_timer_cnt
//   WIDTH-bit count register with load, decrement and hold. Load wins over
//   decrement; with neither asserted the value holds. The controlling FSM
//   guarantees dec is never asserted at zero.
//
// Ports
//   clk     in   clock, rising-edge active
//   clr_n   in   asynchronous active-low clear (count -> 0)
//   ld      in   synchronous load strobe
//   ld_val  in   [WIDTH] value captured on ld
//   dec     in   synchronous decrement strobe
//   count   out  [WIDTH] registered count
// -----------------------------------------------------------------------------
module down_timer_cnt
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule : down_timer_cnt

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//   Loadable down-counter with terminal-count pulse and optional auto-reload.
//   FSM: IDLE -> (load!=0) -> RUN -> (count reaches 0) -> EXPIRE ->
//        RUN (reload_en and reload!=0, count restored) or IDLE.
//   tc and busy decode from the state register only.
//
// Configuration
//   DOWN_TIMER_PRST_EN : adds input prst; prst=1 sets count to all-ones and
//                        state to RUN (reload unchanged), below clr_n and
//                        above load in priority.
//
// Ports
//   clk        in   clock, rising-edge active
//   clr_n      in   asynchronous active-low reset
//   prst       in   synchronous preset (only with DOWN_TIMER_PRST_EN)
//   load       in   synchronous load strobe
//   load_val   in   [WIDTH] start value for count and reload register
//   en         in   count enable (effective in RUN only)
//   reload_en  in   auto-reload select, sampled in EXPIRE
//   count      out  [WIDTH] current count
//   tc         out  high while state is EXPIRE
//   busy       out  high while state is not IDLE
// -----------------------------------------------------------------------------
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
`ifdef DOWN_TIMER_PRST_EN
  input  logic             prst,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             cnt_ld, cnt_dec;
  logic [WIDTH-1:0] cnt_val;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    reload_nxt = reload;
    cnt_ld     = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = load_val;

`ifdef DOWN_TIMER_PRST_EN
    if (prst) begin
      cnt_ld    = 1'b1;
      cnt_val   = '1;
      state_nxt = RUN;
    end else
`endif
    if (load) begin
      cnt_ld     = 1'b1;
      cnt_val    = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else begin
      unique case (state)
        RUN: begin
          if (en) begin
            if (count == WIDTH'(1)) begin
              cnt_dec   = 1'b1;
              state_nxt = EXPIRE;
            end else if (count != '0) begin
              // Zero in RUN is unreachable; the guard only prevents a wrap.
              cnt_dec = 1'b1;
            end
          end
        end
        EXPIRE: begin
          if (reload_en && (reload != '0)) begin
            cnt_ld    = 1'b1;
            cnt_val   = reload;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      reload <= '0;
    end else begin
      state  <= state_nxt;
      reload <= reload_nxt;
    end
  end

  down_timer_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .clr_n  (clr_n),
    .ld     (cnt_ld),
    .ld_val (cnt_val),
    .dec    (cnt_dec),
    .count  (count)
  );

  assign tc   = (state == EXPIRE);
  assign busy = (state != IDLE);

endmodule : down_timer

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
//   Self-checking bench for down_timer (WIDTH=4). Expected {count,tc,busy}
//   triples are pushed to a scoreboard queue as stimulus is applied and popped
//   after the following clock edge (or immediately for asynchronous reset).
//   Define DOWN_TIMER_PRST_EN to also exercise the preset input.
// -----------------------------------------------------------------------------
module tb_down_timer;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr_n;
`ifdef DOWN_TIMER_PRST_EN
  logic         prst = 1'b0;
`endif
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         reload_en;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  exp_t sb[$];
  exp_t e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  down_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
`ifdef DOWN_TIMER_PRST_EN
    .prst      (prst),
`endif
    .load      (load),
    .load_val  (load_val),
    .en        (en),
    .reload_en (reload_en),
    .count     (count),
    .tc        (tc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic ld, input logic [W-1:0] val,
                       input logic e_in, input logic rel);
    load      = ld;
    load_val  = val;
    en        = e_in;
    reload_en = rel;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int c, input logic t, input logic b);
    exp_t r;
    r.count = W'(c);
    r.tc    = t;
    r.busy  = b;
    return r;
  endfunction

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    clr_n = 1'b0;
    #2;
    sb.push_back(mk(0, 1'b0, 1'b0));
    e = sb.pop_front();
    tests_run++;
    if ({count, tc, busy} !== e) begin
      tests_failed++;
      $display("FAIL reset_state: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
               count, tc, busy, e.count, e.tc, e.busy);
    end
    tick();
    clr_n = 1'b1;
    // No load after reset: en and reload_en alone must not leave IDLE.
    drive(1'b0, W'(9), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(0, 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL post_reset_idle[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    drive(1'b1, W'(5), 1'b1, 1'b0);
    sb.push_back(mk(5, 1'b0, 1'b1));
    sb.push_back(mk(4, 1'b0, 1'b1));
    sb.push_back(mk(3, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      load = 1'b0;
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL mid_reset_run[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
    #1;
    clr_n = 1'b0;
    #1;
    sb.push_back(mk(0, 1'b0, 1'b0));
    e = sb.pop_front();
    tests_run++;
    if ({count, tc, busy} !== e) begin
      tests_failed++;
      $display("FAIL mid_reset_async: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
               count, tc, busy, e.count, e.tc, e.busy);
    end
    #1;
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(0, 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL mid_reset_idle[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
  endtask

  task automatic test_one_shot();
    drive(1'b1, W'(3), 1'b1, 1'b0);
    sb.push_back(mk(3, 1'b0, 1'b1));
    sb.push_back(mk(2, 1'b0, 1'b1));
    sb.push_back(mk(1, 1'b0, 1'b1));
    sb.push_back(mk(0, 1'b1, 1'b1));
    sb.push_back(mk(0, 1'b0, 1'b0));
    sb.push_back(mk(0, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      tick();
      load = 1'b0;
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL one_shot[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
  endtask

  task automatic test_auto_reload();
    drive(1'b1, W'(2), 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      sb.push_back(mk(2, 1'b0, 1'b1));
      sb.push_back(mk(1, 1'b0, 1'b1));
      sb.push_back(mk(0, 1'b1, 1'b1));
    end
    sb.push_back(mk(0, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick();
      load = 1'b0;
      // Drop reload_en while sitting in the last EXPIRE so the timer stops.
      if (i == 8) reload_en = 1'b0;
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL auto_reload[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic en_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    drive(1'b1, W'(4), 1'b0, 1'b0);
    sb.push_back(mk(4, 1'b0, 1'b1));
    sb.push_back(mk(3, 1'b0, 1'b1));
    sb.push_back(mk(3, 1'b0, 1'b1));
    sb.push_back(mk(2, 1'b0, 1'b1));
    sb.push_back(mk(1, 1'b0, 1'b1));
    sb.push_back(mk(0, 1'b1, 1'b1));
    sb.push_back(mk(0, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) begin
      tick();
      load = 1'b0;
      en   = (i < 5) ? en_seq[i] : 1'b1;
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL enable_gating[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
  endtask

  task automatic test_load_boundaries();
    // load=0 from IDLE, then load=0 aborting a run.
    drive(1'b1, W'(0), 1'b1, 1'b1);
    sb.push_back(mk(0, 1'b0, 1'b0));
    sb.push_back(mk(6, 1'b0, 1'b1));
    sb.push_back(mk(0, 1'b0, 1'b0));
    sb.push_back(mk(0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      tick();
      load     = (i < 2);
      load_val = (i == 0) ? W'(6) : W'(0);
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL load_zero[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
    // Reach EXPIRE, then load 7 while tc is high.
    drive(1'b1, W'(1), 1'b1, 1'b0);
    sb.push_back(mk(1, 1'b0, 1'b1));
    sb.push_back(mk(0, 1'b1, 1'b1));
    sb.push_back(mk(0, 1'b1, 1'b1));
    sb.push_back(mk(7, 1'b0, 1'b1));
    sb.push_back(mk(6, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        // Same cycle as the load: still in EXPIRE, tc still high.
        #1;
        e = sb.pop_front();
        tests_run++;
        if ({count, tc, busy} !== e) begin
          tests_failed++;
          $display("FAIL load_in_expire_same_cycle: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                   count, tc, busy, e.count, e.tc, e.busy);
        end
      end
      tick();
      load = (i == 1);
      load_val = W'(7);
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL load_in_expire[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
    // Return to IDLE for the next scenario.
    drive(1'b1, W'(0), 1'b0, 1'b0);
    tick();
    load = 1'b0;
  endtask

`ifdef DOWN_TIMER_PRST_EN
  task automatic test_prst();
    drive(1'b0, W'(3), 1'b0, 1'b0);
    prst = 1'b1;
    sb.push_back(mk(15, 1'b0, 1'b1));
    sb.push_back(mk(15, 1'b0, 1'b1));
    sb.push_back(mk(14, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      // Second cycle: prst together with load must still win.
      load = (i == 0);
      prst = (i == 0);
      en   = (i == 1);
      e = sb.pop_front();
      tests_run++;
      if ({count, tc, busy} !== e) begin
        tests_failed++;
        $display("FAIL prst[%0d]: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                 i, count, tc, busy, e.count, e.tc, e.busy);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_count();
    test_one_shot();
    test_auto_reload();
    test_enable_gating();
    test_load_boundaries();
`ifdef DOWN_TIMER_PRST_EN
    test_prst();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_down_timer
